calc_sequencer: RTL and testbench

- Sequences the calculator's shared 8-bit add/subtract datapath.
- Accepts operand tokens over a valid/ready input: operand A with its opcode first, then operand B.
- Drives the combinational ALU, waits a fixed settle time for the ripple chain, then captures the result.
- Derives carry/borrow and zero flags and presents the result on a valid/ready output until it is consumed.

---
 rtl/calc_sequencer_if.sv | 30 +++
 rtl/calc_sequencer.sv | 103 ++++++++++
 tb/tb_calc_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/calc_sequencer_if.sv
// Handshake and datapath bundle between the calculator sequencer and its environment.
// The master side is the sequencer; the slave side is the token source, ALU and result consumer.
interface calc_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sub;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_sub;
    logic [WIDTH-1:0] alu_result;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_c;
    logic             res_z;
    logic             busy;

    modport master (
        input  in_valid, in_data, in_sub, alu_result, res_ready,
        output in_ready, alu_a, alu_b, alu_sub, res_valid, res_data, res_c, res_z, busy
    );

    modport slave (
        output in_valid, in_data, in_sub, alu_result, res_ready,
        input  in_ready, alu_a, alu_b, alu_sub, res_valid, res_data, res_c, res_z, busy
    );
endinterface

// File: rtl/calc_sequencer.sv
// Sequences the shared add/subtract datapath: collects A (with opcode) and B, holds them
// on the ALU for a settle window, captures result and flags, then offers it on valid/ready.
module calc_sequencer #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    calc_sequencer_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_B = 2'd1,
        EXEC   = 2'd2,
        RESULT = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic             r_alu_sub;
    logic [WIDTH-1:0] r_res_data;
    logic             r_res_c;
    logic             r_res_z;
    logic             r_res_valid;

    logic w_in_ready;
    logic w_accept;
    logic w_res_take;
    logic w_res_c;

    // Ready depends only on state and clr, so the source never sees a path from its own valid.
    assign w_in_ready = ((r_state == IDLE) || (r_state == WAIT_B)) && !clr;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_res_take = r_res_valid && bus.res_ready;
    assign w_res_c    = r_alu_sub ? (r_alu_a < r_alu_b) : (bus.alu_result < r_alu_a);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sub   <= 1'b0;
            r_res_data  <= '0;
            r_res_c     <= 1'b0;
            r_res_z     <= 1'b0;
            r_res_valid <= 1'b0;
        end else if (clr) begin
            r_state     <= IDLE;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_alu_a   <= bus.in_data;
                        r_alu_sub <= bus.in_sub;
                        r_state   <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (w_accept) begin
                        r_alu_b <= bus.in_data;
                        r_cnt   <= SETTLE_LOAD;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_cnt == 4'd0) begin
                        r_res_data  <= bus.alu_result;
                        r_res_z     <= (bus.alu_result == '0);
                        r_res_c     <= w_res_c;
                        r_res_valid <= 1'b1;
                        r_state     <= RESULT;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESULT: begin
                    if (w_res_take) begin
                        r_res_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_sub   = r_alu_sub;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_c     = r_res_c;
    assign bus.res_z     = r_res_z;
    assign bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a behavioural 8-bit add/subtract datapath.
module tb_calc_sequencer;
    logic clk;
    logic rst_n;
    logic clr;
    int   checks;
    int   errors;

    calc_sequencer_if #(.WIDTH(8)) bus ();

    calc_sequencer #(.WIDTH(8), .SETTLE_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    assign bus.alu_result = bus.alu_sub ? (bus.alu_a - bus.alu_b) : (bus.alu_a + bus.alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one token and steps past the edge that accepts it (bounded wait).
    task automatic send(input string tag, input logic [7:0] data, input logic sub);
        bit done;
        done = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_sub   = sub;
        for (int i = 0; i < 20 && !done; i++) begin
            if (bus.in_ready) done = 1;
            step();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $error("FAIL %s_accept obs=timeout exp=accepted", tag);
        end
    endtask

    // Full operation with res_ready high: result for exactly one cycle, two edges after B.
    task automatic op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic sub,
                      input logic [7:0] exp_r, input logic exp_c, input logic exp_z);
        bus.res_ready = 1'b1;
        send(tag, a, sub);
        send(tag, b, 1'b0);
        check({tag, "_exec_valid"}, 32'(bus.res_valid), 32'd0);
        check({tag, "_exec_ready"}, 32'(bus.in_ready), 32'd0);
        step();
        check({tag, "_lat1_valid"}, 32'(bus.res_valid), 32'd0);
        step();
        check({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
        check({tag, "_data"}, 32'(bus.res_data), 32'(exp_r));
        check({tag, "_c"}, 32'(bus.res_c), 32'(exp_c));
        check({tag, "_z"}, 32'(bus.res_z), 32'(exp_z));
        check({tag, "_alu_sub"}, 32'(bus.alu_sub), 32'(sub));
        step();
        check({tag, "_drop"}, 32'(bus.res_valid), 32'd0);
        check({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
        $display("op %s a=%02h b=%02h sub=%0d -> r=%02h c=%0d z=%0d", tag, a, b, sub, exp_r, exp_c, exp_z);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        clr = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        bus.in_sub = 1'b0;
        bus.res_ready = 1'b0;
        repeat (3) step();
        check("rst_valid", 32'(bus.res_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_data", 32'(bus.res_data), 32'd0);
        check("rst_alu", {15'd0, bus.alu_sub, bus.alu_a, bus.alu_b}, 32'd0);
        check("rst_flags", {30'd0, bus.res_c, bus.res_z}, 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        #2 rst_n = 1'b1;
        step();

        op("sub_50_20", 8'h50, 8'h20, 1'b1, 8'h30, 1'b0, 1'b0);
        op("sub_20_50", 8'h20, 8'h50, 1'b1, 8'hD0, 1'b1, 1'b0);
        op("sub_33_33", 8'h33, 8'h33, 1'b1, 8'h00, 1'b0, 1'b1);
        op("add_F0_20", 8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 1'b0);
        op("add_00_00", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);

        // Backpressure with a pending token held by the source.
        bus.res_ready = 1'b0;
        send("bp", 8'h10, 1'b0);
        send("bp", 8'h05, 1'b0);
        step();
        step();
        bus.in_valid = 1'b1;
        bus.in_data = 8'h77;
        bus.in_sub = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 32'(bus.res_valid), 32'd1);
            check("bp_data", 32'(bus.res_data), 32'h15);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_alu_a", 32'(bus.alu_a), 32'h10);
            step();
        end
        bus.res_ready = 1'b1;
        step();
        check("bp_release_valid", 32'(bus.res_valid), 32'd0);
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        check("bp_release_busy", 32'(bus.busy), 32'd0);
        step();
        bus.in_valid = 1'b0;
        check("bp_pending_a", 32'(bus.alu_a), 32'h77);
        check("bp_pending_busy", 32'(bus.busy), 32'd1);
        send("bp_b", 8'h01, 1'b1);
        step();
        step();
        check("bp_pending_data", 32'(bus.res_data), 32'h78);
        check("bp_pending_valid", 32'(bus.res_valid), 32'd1);
        step();
        $display("op backpressure held 10 cycles, pending token 77+01 -> 78");

        // Abort mid-EXEC with a competing token.
        send("abort", 8'h40, 1'b0);
        send("abort", 8'h02, 1'b0);
        clr = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 8'hAA;
        #1;
        check("abort_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        bus.in_valid = 1'b0;
        check("abort_valid", 32'(bus.res_valid), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_alu_a", 32'(bus.alu_a), 32'h40);
        repeat (3) begin
            step();
            check("abort_no_result", 32'(bus.res_valid), 32'd0);
        end
        $display("op abort during EXEC, token AA dropped");
        op("sub_09_04", 8'h09, 8'h04, 1'b1, 8'h05, 1'b0, 1'b0);

        // Asynchronous reset in RESULT, between clock edges.
        bus.res_ready = 1'b0;
        send("arst", 8'h50, 1'b1);
        send("arst", 8'h20, 1'b0);
        step();
        step();
        check("arst_pre_valid", 32'(bus.res_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.res_valid), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_data", 32'(bus.res_data), 32'd0);
        check("arst_alu", {15'd0, bus.alu_sub, bus.alu_a, bus.alu_b}, 32'd0);
        check("arst_flags", {30'd0, bus.res_c, bus.res_z}, 32'd0);
        #1 rst_n = 1'b1;
        step();
        $display("op async reset during RESULT");
        op("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
